// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO sweep controller: register map, CTRL/STATUS
// bit positions, sequencer state encoding and the Wishbone byte-merge helper.
package nco_sweep_pkg;

   // Register word index, decoded from wbs_adr_i[4:2]
   localparam logic [2:0] REG_CTRL      = 3'd0;  // 0x00
   localparam logic [2:0] REG_START_INC = 3'd1;  // 0x04
   localparam logic [2:0] REG_STOP_INC  = 3'd2;  // 0x08
   localparam logic [2:0] REG_STEP      = 3'd3;  // 0x0C
   localparam logic [2:0] REG_DWELL     = 3'd4;  // 0x10
   localparam logic [2:0] REG_STATUS    = 3'd5;  // 0x14

   // CTRL bits
   localparam int CTRL_START = 0;
   localparam int CTRL_CHIRP = 1;
   localparam int CTRL_LOOP  = 2;
   localparam int CTRL_ABORT = 3;

   // STATUS bits
   localparam int STATUS_BUSY     = 0;
   localparam int STATUS_DONE     = 1;
   localparam int STATUS_INCR_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Only byte lanes 0 and 1 carry register data; lanes 2 and 3 keep the
   // old (zero-extended) contents, so they are effectively ignored.
   function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
      logic [31:0] r;
      r = old_val;
      if (sel[0]) r[7:0]  = wdat[7:0];
      if (sel[1]) r[15:8] = wdat[15:8];
      return r;
   endfunction

endpackage

// File: rtl/nco_sweep_ctrl_regs.sv
// Wishbone slave for the sweep controller: address decode, configuration
// register file, done-sticky flag, registered acknowledge and read data.
//
// Handshake: a request is accepted on a clock edge where cyc & stb & !ack.
// Writes commit and read data is captured on that same edge; ack is high for
// exactly the following cycle, which also blocks a second accept, so every
// transfer takes at least two cycles.
module nco_sweep_ctrl_regs
   import nco_sweep_pkg::*;
#(
   parameter int BITS       = 16,
   parameter int DWELL_BITS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,
   // live status from the sequencer
   input  logic                  busy_i,
   input  logic [BITS-1:0]       incr_i,
   input  logic                  done_i,
   // command pulses, combinational from the accepted write
   output logic                  start_o,
   output logic                  abort_o,
   // configuration as it will be after this edge, so a START written together
   // with CHIRP/LOOP launches with the freshly written mode bits
   output logic                  cfg_chirp_o,
   output logic                  cfg_loop_o,
   output logic [BITS-1:0]       cfg_start_inc_o,
   output logic [BITS-1:0]       cfg_stop_inc_o,
   output logic [BITS-1:0]       cfg_step_o,
   output logic [DWELL_BITS-1:0] cfg_dwell_o
);

   logic                  ack_q;
   logic [31:0]           rdat_q, rdat_d;
   logic                  chirp_q, chirp_d;
   logic                  loop_q, loop_d;
   logic [BITS-1:0]       start_inc_q, start_inc_d;
   logic [BITS-1:0]       stop_inc_q, stop_inc_d;
   logic [BITS-1:0]       step_q, step_d;
   logic [DWELL_BITS-1:0] dwell_q, dwell_d;
   logic                  done_sticky_q, done_sticky_d;

   logic       accept;
   logic       wr_en;
   logic       rd_en;
   logic [2:0] idx;
   logic       ctrl_wr;

   assign accept  = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign wr_en   = accept & wbs_we_i;
   assign rd_en   = accept & ~wbs_we_i;
   assign idx     = wbs_adr_i[4:2];
   assign ctrl_wr = wr_en & (idx == REG_CTRL) & wbs_sel_i[0];

   assign start_o = ctrl_wr & wbs_dat_i[CTRL_START];
   assign abort_o = ctrl_wr & wbs_dat_i[CTRL_ABORT];

   logic unused_bits;
   assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

   // Next register values from the accepted write; done_sticky set beats read-clear
   always_comb begin
      chirp_d       = chirp_q;
      loop_d        = loop_q;
      start_inc_d   = start_inc_q;
      stop_inc_d    = stop_inc_q;
      step_d        = step_q;
      dwell_d       = dwell_q;
      done_sticky_d = done_sticky_q;
      if (ctrl_wr) begin
         chirp_d = wbs_dat_i[CTRL_CHIRP];
         loop_d  = wbs_dat_i[CTRL_LOOP];
      end
      if (wr_en) begin
         case (idx)
            REG_START_INC: start_inc_d = BITS'(wb_merge(32'(start_inc_q), wbs_dat_i, wbs_sel_i));
            REG_STOP_INC:  stop_inc_d  = BITS'(wb_merge(32'(stop_inc_q), wbs_dat_i, wbs_sel_i));
            REG_STEP:      step_d      = BITS'(wb_merge(32'(step_q), wbs_dat_i, wbs_sel_i));
            REG_DWELL:     dwell_d     = DWELL_BITS'(wb_merge(32'(dwell_q), wbs_dat_i, wbs_sel_i));
            default: ;
         endcase
      end
      if (rd_en && idx == REG_STATUS) done_sticky_d = 1'b0;
      if (done_i) done_sticky_d = 1'b1;
   end

   // Readback multiplexer; START/ABORT are pulses and read as 0
   always_comb begin
      rdat_d = '0;
      if (rd_en) begin
         case (idx)
            REG_CTRL: begin
               rdat_d[CTRL_CHIRP] = chirp_q;
               rdat_d[CTRL_LOOP]  = loop_q;
            end
            REG_START_INC: rdat_d = 32'(start_inc_q);
            REG_STOP_INC:  rdat_d = 32'(stop_inc_q);
            REG_STEP:      rdat_d = 32'(step_q);
            REG_DWELL:     rdat_d = 32'(dwell_q);
            REG_STATUS: begin
               rdat_d[STATUS_BUSY] = busy_i;
               rdat_d[STATUS_DONE] = done_sticky_q;
               rdat_d[STATUS_INCR_LSB +: 16] = 16'(incr_i);
            end
            default: ;
         endcase
      end
   end

   // Register file, ack and read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q         <= 1'b0;
         rdat_q        <= '0;
         chirp_q       <= 1'b0;
         loop_q        <= 1'b0;
         start_inc_q   <= '0;
         stop_inc_q    <= '0;
         step_q        <= '0;
         dwell_q       <= '0;
         done_sticky_q <= 1'b0;
      end else begin
         ack_q         <= accept;
         rdat_q        <= rdat_d;
         chirp_q       <= chirp_d;
         loop_q        <= loop_d;
         start_inc_q   <= start_inc_d;
         stop_inc_q    <= stop_inc_d;
         step_q        <= step_d;
         dwell_q       <= dwell_d;
         done_sticky_q <= done_sticky_d;
      end
   end

   assign wbs_ack_o       = ack_q;
   assign wbs_dat_o       = rdat_q;
   assign cfg_chirp_o     = chirp_d;
   assign cfg_loop_o      = loop_d;
   assign cfg_start_inc_o = start_inc_d;
   assign cfg_stop_inc_o  = stop_inc_d;
   assign cfg_step_o      = step_d;
   assign cfg_dwell_o     = dwell_d;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO phase-increment sequencer: fixed tone or linear chirp with dwell, loop,
// abort and a one-cycle done pulse. Config is shadowed at START so bus writes
// during a run never disturb the sequence in flight.
module nco_sweep_ctrl
   import nco_sweep_pkg::*;
#(
   parameter int BITS       = 16,
   parameter int DWELL_BITS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [BITS-1:0] incr_o,
   output logic            busy_o,
   output logic            done_o
);

   logic                  start_p, abort_p;
   logic                  cfg_chirp, cfg_loop;
   logic [BITS-1:0]       cfg_start_inc, cfg_stop_inc, cfg_step;
   logic [DWELL_BITS-1:0] cfg_dwell;

   nco_sweep_ctrl_regs #(
      .BITS       (BITS),
      .DWELL_BITS (DWELL_BITS)
   ) u_regs (
      .clk             (clk),
      .rst             (rst),
      .wbs_stb_i       (wbs_stb_i),
      .wbs_cyc_i       (wbs_cyc_i),
      .wbs_we_i        (wbs_we_i),
      .wbs_sel_i       (wbs_sel_i),
      .wbs_adr_i       (wbs_adr_i),
      .wbs_dat_i       (wbs_dat_i),
      .wbs_ack_o       (wbs_ack_o),
      .wbs_dat_o       (wbs_dat_o),
      .busy_i          (busy_o),
      .incr_i          (incr_o),
      .done_i          (done_o),
      .start_o         (start_p),
      .abort_o         (abort_p),
      .cfg_chirp_o     (cfg_chirp),
      .cfg_loop_o      (cfg_loop),
      .cfg_start_inc_o (cfg_start_inc),
      .cfg_stop_inc_o  (cfg_stop_inc),
      .cfg_step_o      (cfg_step),
      .cfg_dwell_o     (cfg_dwell)
   );

   state_e state_q, state_d;

   logic [BITS-1:0]       cur_q, cur_d;
   logic [DWELL_BITS-1:0] dwell_q, dwell_d;
   logic [BITS-1:0]       sh_start_q, sh_stop_q, sh_step_q;
   logic [DWELL_BITS-1:0] sh_dwell_q;
   logic                  sh_chirp_q, sh_loop_q;

   logic          launch;
   logic          expire;
   logic          hold;
   logic [BITS:0] next_w;
   logic          past_stop;

   // START is honoured only when not running; ABORT in the same write wins
   assign launch    = start_p & ~abort_p & (state_q != ST_RUN);
   assign expire    = (state_q == ST_RUN) & (dwell_q == '0);
   assign hold      = ~sh_chirp_q | (sh_step_q == '0);
   // One extra bit so an overflowing step ends the sweep instead of wrapping
   assign next_w    = {1'b0, cur_q} + {1'b0, sh_step_q};
   assign past_stop = next_w > {1'b0, sh_stop_q};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (abort_p) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (launch) state_d = ST_RUN;
            ST_RUN:  if (expire && !hold && past_stop && !sh_loop_q) state_d = ST_DONE;
            ST_DONE: state_d = launch ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from the state register
   always_comb begin
      busy_o = (state_q == ST_RUN);
      done_o = (state_q == ST_DONE);
      incr_o = (state_q == ST_RUN) ? cur_q : '0;
   end

   // Current increment and dwell counter: load at launch, step at dwell expiry
   always_comb begin
      cur_d   = cur_q;
      dwell_d = dwell_q;
      if (launch) begin
         cur_d   = cfg_start_inc;
         dwell_d = cfg_dwell;
      end else if (state_q == ST_RUN) begin
         if (dwell_q != '0) begin
            dwell_d = dwell_q - DWELL_BITS'(1);
         end else begin
            dwell_d = sh_dwell_q;
            if (!hold) begin
               if (!past_stop)     cur_d = next_w[BITS-1:0];
               else if (sh_loop_q) cur_d = sh_start_q;
            end
         end
      end
   end

   // Datapath registers and shadow copy of the configuration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q      <= '0;
         dwell_q    <= '0;
         sh_start_q <= '0;
         sh_stop_q  <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
         sh_chirp_q <= 1'b0;
         sh_loop_q  <= 1'b0;
      end else begin
         cur_q   <= cur_d;
         dwell_q <= dwell_d;
         if (launch) begin
            sh_start_q <= cfg_start_inc;
            sh_stop_q  <= cfg_stop_inc;
            sh_step_q  <= cfg_step;
            sh_dwell_q <= cfg_dwell;
            sh_chirp_q <= cfg_chirp;
            sh_loop_q  <= cfg_loop;
         end
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: register access, tone, chirp, overflow,
// loop with mid-run config writes, async reset and START+ABORT.
module tb_nco_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0;
   logic [31:0] dat = '0;
   logic        ack;
   logic [31:0] rdat;
   logic [15:0] incr;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   nco_sweep_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .incr_o    (incr),
      .busy_o    (busy),
      .done_o    (done)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One Wishbone transfer; returns 1 ns after the accept edge
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
      int n;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ack !== 1'b1 && n < 20);
      r = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (ack !== 1'b1) begin
         checks++;
         errors++;
         $error("FAIL wb_timeout: observed ack=%b expected ack=1 within 20 cycles", ack);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      wb_xfer(1'b1, a, d, 4'hF, r);
   endtask

   task automatic wr_sel(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      wb_xfer(1'b1, a, d, s, r);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      wb_xfer(1'b0, a, 32'h0, 4'hF, r);
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] r;
      int e0, k, bad, done_seen;

      // ---------------- reset state ----------------
      #12;
      check("rst_incr", 32'(incr), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_ack",  32'(ack),  32'h0);
      @(negedge clk); rst = 1'b0;
      for (int a = 0; a <= 'h18; a += 4) begin
         rd(32'(a), r);
         check($sformatf("rst_read_%02h", a), r, 32'h0);
      end

      // ---------------- register access / byte lanes ----------------
      wr_sel(32'h08, 32'h5555ABCD, 4'b0011);
      rd(32'h08, r);
      check("stop_sel_lo16", r, 32'h0000ABCD);
      wr_sel(32'h08, 32'h0012FF77, 4'b0001);
      rd(32'h08, r);
      check("stop_sel_byte0", r, 32'h0000AB77);
      wr(32'h18, 32'h1234);
      rd(32'h18, r);
      check("unmapped_read", r, 32'h0);
      wr(32'h00, 32'h6);
      rd(32'h00, r);
      check("ctrl_readback", r, 32'h6);
      check("ctrl_no_start", 32'(busy), 32'h0);
      wr(32'h00, 32'h0);

      // ---------------- tone ----------------
      wr(32'h04, 32'h0100);
      wr(32'h00, 32'h1);
      bad = 0; done_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         if (incr !== 16'h0100 || busy !== 1'b1) bad++;
         if (done === 1'b1) done_seen++;
         step();
      end
      check("tone_bad_cycles", 32'(bad), 32'h0);
      check("tone_done_seen", 32'(done_seen), 32'h0);
      wr(32'h00, 32'h8);
      check("tone_abort_incr", 32'(incr), 32'h0);
      check("tone_abort_busy", 32'(busy), 32'h0);
      step();
      check("tone_abort_nodone", 32'(done), 32'h0);

      // ---------------- chirp ----------------
      wr(32'h04, 32'h0010);
      wr(32'h08, 32'h0040);
      wr(32'h0C, 32'h0010);
      wr(32'h10, 32'h0002);
      wr(32'h00, 32'h3);
      check("chirp_busy", 32'(busy), 32'h1);
      for (int kk = 0; kk < 12; kk++) begin
         check($sformatf("chirp_val_%0d", kk), 32'(incr), 32'h10 * 32'(kk / 3 + 1));
         step();
      end
      check("chirp_done_pulse", 32'(done), 32'h1);
      check("chirp_done_busy", 32'(busy), 32'h0);
      check("chirp_done_incr", 32'(incr), 32'h0);
      step();
      check("chirp_done_1cyc", 32'(done), 32'h0);
      rd(32'h14, r);
      check("chirp_status_sticky", r, 32'h2);
      rd(32'h14, r);
      check("chirp_status_cleared", r, 32'h0);

      // ---------------- overflow: no wrap ----------------
      wr(32'h04, 32'hFFF0);
      wr(32'h08, 32'hFFFF);
      wr(32'h0C, 32'h0020);
      wr(32'h10, 32'h0000);
      wr(32'h00, 32'h3);
      check("ovf_first", 32'(incr), 32'hFFF0);
      step();
      check("ovf_done", 32'(done), 32'h1);
      check("ovf_done_incr", 32'(incr), 32'h0);
      step();
      check("ovf_no_wrap_incr", 32'(incr), 32'h0);
      check("ovf_idle_busy", 32'(busy), 32'h0);
      rd(32'h14, r);
      check("ovf_status", r, 32'h2);

      // ---------------- loop with mid-run config writes ----------------
      wr(32'h04, 32'h0010);
      wr(32'h08, 32'h0040);
      wr(32'h0C, 32'h0010);
      wr(32'h10, 32'h0002);
      wr(32'h00, 32'h7);
      e0 = cyc_cnt;
      wr(32'h0C, 32'h0001);
      wr(32'h10, 32'h0000);
      wr(32'h08, 32'hFFFF);
      bad = 0; done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         k = cyc_cnt - e0;
         if (incr !== 16'(32'h10 * 32'((k % 12) / 3 + 1))) bad++;
         if (done === 1'b1) done_seen++;
         step();
      end
      check("loop_bad_cycles", 32'(bad), 32'h0);
      check("loop_done_seen", 32'(done_seen), 32'h0);
      k = cyc_cnt - e0;
      rd(32'h14, r);
      check("loop_status", r, {16'(32'h10 * 32'(((k + 1) % 12) / 3 + 1)), 16'h0001});
      wr(32'h00, 32'h8);
      check("loop_abort_incr", 32'(incr), 32'h0);
      check("loop_abort_busy", 32'(busy), 32'h0);

      // ---------------- async reset mid-chirp ----------------
      wr(32'h00, 32'h3);
      step(); step(); step();
      check("prerst_busy", 32'(busy), 32'h1);
      @(negedge clk); rst = 1'b1; #1;
      check("arst_incr", 32'(incr), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_done", 32'(done), 32'h0);
      @(negedge clk); rst = 1'b0;
      rd(32'h14, r);
      check("arst_status", r, 32'h0);
      rd(32'h08, r);
      check("arst_stop_cleared", r, 32'h0);

      // ---------------- START and ABORT in one write ----------------
      wr(32'h04, 32'h0055);
      wr(32'h00, 32'h9);
      check("sa_busy", 32'(busy), 32'h0);
      check("sa_incr", 32'(incr), 32'h0);
      done_seen = 0; bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (done === 1'b1) done_seen++;
         if (busy !== 1'b0) bad++;
         step();
      end
      check("sa_no_done", 32'(done_seen), 32'h0);
      check("sa_stay_idle", 32'(bad), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Wishbone-programmable sequencer that generates the per-cycle phase increment fed to the phase-accumulator counter ahead of the CORDIC sin/cos stage and the two sigma-delta DACs. It replaces the raw `io_in`-driven increment with either a fixed tone or a linear frequency chirp (start/stop/step/dwell), with loop, abort and done-interrupt support. It sits between the Wishbone slave port and the integrator's `incr` input.

## Interface
Parameters:
- `BITS`, 16, width of increment and config registers
- `DWELL_BITS`, 16, width of dwell counter/register

Ports:
- `clk`  in  1  system clock (integrator clock domain)
- `rst`  in  1  asynchronous, active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe/cycle/write
- `wbs_sel_i`  in  4  byte selects; bytes 0..1 honoured, 2..3 ignored
- `wbs_adr_i`  in  32  byte address; decode on `[4:2]`
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  registered acknowledge
- `wbs_dat_o`  out  32  read data, valid with ack
- `incr_o`  out  BITS  phase increment to integrator
- `busy_o`  out  1  sweep/tone running
- `done_o`  out  1  one-cycle pulse at end of a non-looping chirp (to irq)

## Operation
- Registers (offset): 0x00 CTRL {bit0 START (W1, self-clearing), bit1 CHIRP, bit2 LOOP, bit3 ABORT (W1, self-clearing)}; 0x04 START_INC; 0x08 STOP_INC; 0x0C STEP; 0x10 DWELL; 0x14 STATUS read-only {bit0 busy, bit1 done_sticky (cleared by read), bits[31:16] current incr}. Unmapped reads return 0; unmapped writes ignored.
- Reset: all registers 0, state IDLE, `incr_o`=0, `busy_o`=0, `done_o`=0, `wbs_ack_o`=0, `wbs_dat_o`=0.
- On START, START_INC/STOP_INC/STEP/DWELL/CHIRP/LOOP are copied into shadow registers; later config writes do not affect the running sequence.
- States: IDLE (`incr_o`=0) -> RUN on START. RUN: `incr_o`=cur; dwell counter loaded with DWELL, decrements each cycle; each value held DWELL+1 cycles. At dwell expiry in RUN:
  - CHIRP=0 or STEP=0: reload dwell, cur unchanged (tone runs until ABORT).
  - next = cur+STEP computed BITS+1 wide, unsigned. If next > STOP: LOOP=1 -> cur=START; LOOP=0 -> DONE. Else cur=next.
- DONE: one cycle, `done_o`=1, `incr_o`=0, sets done_sticky; -> IDLE.
- START_INC > STOP_INC: START emitted for one dwell period, then end-of-sweep rule applies.
- ABORT in any state: -> IDLE next edge, `incr_o`=0, no done pulse. ABORT and START in the same write: ABORT wins.
- START while busy: ignored (no restart).

## Timing
- Wishbone: request accepted on edge where `cyc&stb&!ack`; write committed and read data captured on that edge; `wbs_ack_o` high exactly one cycle after; no back-to-back acks (min 2 cycles/transfer).
- START accepted at edge E0: `busy_o`=1 and `incr_o`=START_INC from E0.
- Value k (0-based) of a chirp appears at E0 + k·(DWELL+1).
- Chirp end at dwell expiry edge Ex: DONE for cycle after Ex (`done_o`=1, `busy_o`=0), IDLE following edge.
- ABORT accepted at edge Ea: `incr_o`=0, `busy_o`=0 from Ea.
- STATUS read returns values sampled at the accept edge; done_sticky clears at that same edge unless a DONE sets it simultaneously (set wins).
- `rst` asserted mid-sweep: all outputs to reset values immediately (async).

## Structure
- Package `nco_sweep_pkg`: register offsets, CTRL/STATUS bit indices, state enum {IDLE, RUN, DONE}.
- One sub-module natural: `nco_sweep_regs` (Wishbone decode, register file, ack/readback); the sequencer FSM and shadow/dwell/cur datapath stay in the top.

## Test plan
- Reset then read all offsets -> all 0; `incr_o`=0, `busy_o`=0.
- Tone: START_INC=0x0100, CHIRP=0, START -> `incr_o`=0x0100 every cycle for 1000 cycles, `done_o` never asserted; ABORT -> `incr_o`=0 on accept edge.
- Chirp: START=0x0010, STOP=0x0040, STEP=0x0010, DWELL=2 -> 0x10,0x20,0x30,0x40 each for 3 cycles, then one-cycle `done_o`, STATUS bit1=1 then 0 after read.
- Overflow: START=0xFFF0, STOP=0xFFFF, STEP=0x0020, DWELL=0 -> single value 0xFFF0 for 1 cycle, then done (no wrap to 0x0010).
- Loop: same chirp as scenario 3 with LOOP=1 -> sequence repeats from 0x10 after 0x40, no `done_o`; config write mid-run leaves sequence unchanged.
- Async `rst` pulsed mid-chirp and START+ABORT in one write -> outputs at reset values / IDLE, no `done_o`.
